// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the intersection phase controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_INIT        = 3'd0,
    ST_MAIN_GREEN  = 3'd1,
    ST_MAIN_YELLOW = 3'd2,
    ST_RED_A       = 3'd3,
    ST_SIDE_GREEN  = 3'd4,
    ST_SIDE_YELLOW = 3'd5,
    ST_RED_B       = 3'd6,
    ST_PED_WALK    = 3'd7
  } phase_state_t;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

endpackage

// File: rtl/traffic_phase_controller_request_latch.sv
// Sticky pedestrian request flag; a new request on the clearing edge survives.
module phase_request_latch (
  input  logic clock,
  input  logic reset_sync,
  input  logic set_req,
  input  logic clear_req,
  output logic pending
);

  always_ff @(posedge clock or posedge reset_sync) begin
    if (reset_sync)
      pending <= 1'b0;
    else if (set_req)
      pending <= 1'b1;
    else if (clear_req)
      pending <= 1'b0;
  end

endmodule

// File: rtl/traffic_phase_controller.sv
// Two-road intersection sequencer driving an external countdown phase timer.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter logic [3:0] T_MAIN_GREEN = 4'd8,
  parameter logic [3:0] T_SIDE_GREEN = 4'd5,
  parameter logic [3:0] T_YELLOW     = 4'd2,
  parameter logic [3:0] T_ALL_RED    = 4'd1,
  parameter logic [3:0] T_WALK       = 4'd6
) (
  input  logic       clock,
  input  logic       reset_sync,
  input  logic       timer_expired,
  input  logic       car_side,
  input  logic       ped_request,
  output logic [3:0] timer_value,
  output logic       timer_start,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk
);

  phase_state_t state, state_next;
  logic         advance;
  logic         start_next;
  logic [3:0]   value_next;
  logic [2:0]   main_next, side_next;
  logic         walk_next;
  logic         ped_pending;
  logic         clear_ped;

  // An expiry landing on our own load pulse belongs to the previous phase.
  assign advance   = timer_expired && !timer_start;
  assign clear_ped = start_next && (state_next == ST_PED_WALK);

  phase_request_latch u_ped_latch (
    .clock      (clock),
    .reset_sync (reset_sync),
    .set_req    (ped_request),
    .clear_req  (clear_ped),
    .pending    (ped_pending)
  );

  always_comb begin
    state_next = state;
    start_next = 1'b0;
    if (state == ST_INIT) begin
      state_next = ST_RED_B;
      start_next = 1'b1;
    end else if (advance) begin
      start_next = 1'b1;
      case (state)
        ST_MAIN_GREEN:  state_next = (car_side || ped_pending) ? ST_MAIN_YELLOW : ST_MAIN_GREEN;
        ST_MAIN_YELLOW: state_next = ST_RED_A;
        ST_RED_A:       state_next = car_side ? ST_SIDE_GREEN : ST_RED_B;
        ST_SIDE_GREEN:  state_next = ST_SIDE_YELLOW;
        ST_SIDE_YELLOW: state_next = ST_RED_B;
        ST_RED_B:       state_next = ped_pending ? ST_PED_WALK : ST_MAIN_GREEN;
        ST_PED_WALK:    state_next = ST_MAIN_GREEN;
        default:        state_next = ST_INIT;
      endcase
    end
  end

  // Duration and lamps are decoded from the upcoming state so they land with the start pulse.
  always_comb begin
    value_next = timer_value;
    main_next  = LAMP_RED;
    side_next  = LAMP_RED;
    walk_next  = 1'b0;
    if (start_next) begin
      case (state_next)
        ST_MAIN_GREEN:                value_next = T_MAIN_GREEN;
        ST_SIDE_GREEN:                value_next = T_SIDE_GREEN;
        ST_MAIN_YELLOW, ST_SIDE_YELLOW: value_next = T_YELLOW;
        ST_PED_WALK:                  value_next = T_WALK;
        default:                      value_next = T_ALL_RED;
      endcase
    end
    case (state_next)
      ST_MAIN_GREEN:  main_next = LAMP_GREEN;
      ST_MAIN_YELLOW: main_next = LAMP_YELLOW;
      ST_SIDE_GREEN:  side_next = LAMP_GREEN;
      ST_SIDE_YELLOW: side_next = LAMP_YELLOW;
      ST_PED_WALK:    walk_next = 1'b1;
      default:        ;
    endcase
  end

  always_ff @(posedge clock or posedge reset_sync) begin
    if (reset_sync) begin
      state       <= ST_INIT;
      timer_start <= 1'b0;
      timer_value <= 4'd0;
      main_light  <= LAMP_RED;
      side_light  <= LAMP_RED;
      walk        <= 1'b0;
    end else begin
      state       <= state_next;
      timer_start <= start_next;
      timer_value <= value_next;
      main_light  <= main_next;
      side_light  <= side_next;
      walk        <= walk_next;
    end
  end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scoreboard bench: a table-driven phase model predicts each timer load; a monitor checks them.
module tb_traffic_phase_controller;

  logic       clock = 1'b0;
  logic       reset_sync;
  logic       timer_expired, car_side, ped_request;
  logic [3:0] timer_value;
  logic       timer_start;
  logic [2:0] main_light, side_light;
  logic       walk;

  traffic_phase_controller dut (
    .clock         (clock),
    .reset_sync    (reset_sync),
    .timer_expired (timer_expired),
    .car_side      (car_side),
    .ped_request   (ped_request),
    .timer_value   (timer_value),
    .timer_start   (timer_start),
    .main_light    (main_light),
    .side_light    (side_light),
    .walk          (walk)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] value;
    logic [2:0] main;
    logic [2:0] side;
    logic       walk;
  } expect_t;

  // Phase indices and per-phase lamp/duration tables taken straight from the phase list.
  localparam int P_INIT = 0, P_MG = 1, P_MY = 2, P_RA = 3, P_SG = 4, P_SY = 5, P_RB = 6, P_PW = 7;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
  logic [2:0] main_tab [8] = '{R, G, Y, R, R, R, R, R};
  logic [2:0] side_tab [8] = '{R, R, R, R, G, Y, R, R};
  logic       walk_tab [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
  logic [3:0] dur_tab  [8] = '{4'd0, 4'd8, 4'd2, 4'd1, 4'd5, 4'd2, 4'd1, 4'd6};

  expect_t sb[$];
  expect_t last_exp;
  int      m_phase;
  bit      m_start, m_ped;
  int      assertions = 0;
  int      failures   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int next_phase(int p, bit car, bit ped);
    case (p)
      P_MG:    return (car || ped) ? P_MY : P_MG;
      P_MY:    return P_RA;
      P_RA:    return car ? P_SG : P_RB;
      P_SG:    return P_SY;
      P_SY:    return P_RB;
      P_RB:    return ped ? P_PW : P_MG;
      P_PW:    return P_MG;
      default: return P_RB;
    endcase
  endfunction

  task automatic modelReset();
    m_phase  = P_INIT;
    m_start  = 0;
    m_ped    = 0;
    last_exp = '{value: 4'd0, main: R, side: R, walk: 1'b0};
    sb.delete();
  endtask

  task automatic modelStep(bit e, bit c, bit p);
    bit go;
    int nxt;
    go  = (m_phase == P_INIT) || (e && !m_start);
    nxt = go ? next_phase(m_phase, c, m_ped) : m_phase;
    if (p) m_ped = 1;
    else if (go && nxt == P_PW) m_ped = 0;
    m_start = go;
    m_phase = nxt;
    if (go) sb.push_back('{value: dur_tab[nxt], main: main_tab[nxt], side: side_tab[nxt], walk: walk_tab[nxt]});
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic applyStimulus(bit e, bit c, bit p);
    timer_expired = e;
    car_side      = c;
    ped_request   = p;
    @(posedge clock);
    modelStep(e, c, p);
    @(negedge clock);
    checkOutput("ped_pending", {31'd0, dut.ped_pending}, {31'd0, m_ped});
  endtask

  task automatic expirePhase(bit c, bit p, int idle);
    repeat (idle) applyStimulus(0, c, 0);
    applyStimulus(1, c, p);
  endtask

  task automatic asyncReset();
    #2 reset_sync = 1'b1;
    #1;
    checkOutput("rst_main", {29'd0, main_light}, {29'd0, R});
    checkOutput("rst_side", {29'd0, side_light}, {29'd0, R});
    checkOutput("rst_walk", {31'd0, walk}, 32'd0);
    checkOutput("rst_start", {31'd0, timer_start}, 32'd0);
    checkOutput("rst_value", {28'd0, timer_value}, 32'd0);
    checkOutput("rst_ped", {31'd0, dut.ped_pending}, 32'd0);
    modelReset();
    timer_expired = 0; car_side = 0; ped_request = 0;
    @(posedge clock);
    @(negedge clock);
    reset_sync = 1'b0;
  endtask

  // Monitor: each load pulse must match the next prediction; between pulses outputs hold.
  initial begin
    expect_t e;
    forever begin
      @(posedge clock);
      #1;
      if (!reset_sync) begin
        if (timer_start) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_start", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            last_exp = e;
            checkOutput("start_value", {28'd0, timer_value}, {28'd0, e.value});
          end
        end else begin
          checkOutput("held_value", {28'd0, timer_value}, {28'd0, last_exp.value});
        end
        checkOutput("main_light", {29'd0, main_light}, {29'd0, last_exp.main});
        checkOutput("side_light", {29'd0, side_light}, {29'd0, last_exp.side});
        checkOutput("walk", {31'd0, walk}, {31'd0, last_exp.walk});
        checkOutput("safety_greens", {31'd0, (main_light != R) && (side_light != R)}, 32'd0);
        checkOutput("safety_walk", {31'd0, walk && ((main_light != R) || (side_light != R))}, 32'd0);
      end
    end
  end

  initial begin
    bit c, guard_hit;
    int guard;
    reset_sync = 1'b1;
    timer_expired = 0; car_side = 0; ped_request = 0;
    modelReset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("init_main", {29'd0, main_light}, {29'd0, R});
    checkOutput("init_value", {28'd0, timer_value}, 32'd0);
    reset_sync = 1'b0;

    $display("[TB] rest on main green");
    applyStimulus(0, 0, 0);
    expirePhase(0, 0, 2);
    repeat (3) expirePhase(0, 0, 3);
    $display("[TB] expiry coincident with start");
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);

    $display("[TB] side-road car cycle");
    repeat (6) expirePhase(1, 0, 1);

    $display("[TB] pedestrian-only cycle");
    applyStimulus(0, 0, 1);
    repeat (5) expirePhase(0, 0, 1);

    $display("[TB] request on walk entry edge");
    applyStimulus(0, 0, 1);
    repeat (3) expirePhase(0, 0, 1);
    expirePhase(0, 1, 1);
    checkOutput("ped_kept", {31'd0, dut.ped_pending}, 32'd1);
    expirePhase(0, 0, 1);
    expirePhase(0, 0, 1);
    checkOutput("left_green_phase", m_phase, P_MY);
    repeat (5) expirePhase(0, 0, 1);

    $display("[TB] async reset in side green");
    guard = 0;
    guard_hit = 0;
    while (m_phase != P_SG && !guard_hit) begin
      expirePhase(1, 0, 1);
      guard++;
      if (guard > 40) guard_hit = 1;
    end
    checkOutput("reached_side_green", {31'd0, guard_hit}, 32'd0);
    asyncReset();

    $display("[TB] randomized run");
    c = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(15) == 0) c = ~c;
      applyStimulus($urandom_range(3) == 0, c, $urandom_range(19) == 0);
      if (i == 5000) asyncReset();
    end
    repeat (3) applyStimulus(0, 0, 0);
    checkOutput("scoreboard_drained", sb.size(), 32'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
